// File: rtl/sys_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_rst.
// Define SYS_RESET_CTRL_WATCHDOG_EN to re-reset the PLL when lock does not arrive within RELOCK_TIMEOUT cycles.
module sys_reset_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int HOLD_CYCLES    = 1024,
  parameter int RELOCK_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_lost_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (MAX_A > RELOCK_TIMEOUT) ? MAX_A : RELOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef SYS_RESET_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] RELOCK_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             lock_lost_count_q, lock_lost_count_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_hold;
  logic                   lk;

  // Assert asynchronously, release two clk edges after rst falls.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= rst_sync_d;
  end

  assign rst_hold = rst_sync_q[1];

  // A locked flag seen while the PLL is held in reset is stale, so the chain is flushed then.
  always_comb begin
    if (state_q == ST_PLL_RST) sync_d = '0;
    else                       sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    lock_lost_count_d = lock_lost_count_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
`ifdef SYS_RESET_CTRL_WATCHDOG_EN
        else if (cnt_q == RELOCK_LAST) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        // Lock loss wins over a completing hold count.
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          if (lock_lost_count_q != 8'hFF) lock_lost_count_d = lock_lost_count_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
    // Outputs decode the next state so they line up with state_q once registered.
    pll_rst_d = (state_d == ST_PLL_RST);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_PLL_RST;
      cnt_q             <= '0;
      lock_lost_count_q <= '0;
      pll_rst_q         <= 1'b1;
      sys_rst_q         <= 1'b1;
      ready_q           <= 1'b0;
    end else if (rst_hold) begin
      state_q           <= ST_PLL_RST;
      cnt_q             <= '0;
      lock_lost_count_q <= '0;
      pll_rst_q         <= 1'b1;
      sys_rst_q         <= 1'b1;
      ready_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      lock_lost_count_q <= lock_lost_count_d;
      pll_rst_q         <= pll_rst_d;
      sys_rst_q         <= sys_rst_d;
      ready_q           <= ready_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign lock_lost_count = lock_lost_count_q;

endmodule
